// File: rtl/exu_resp_bfm.sv
// Execution-unit responder BFM for PDP8 fetch/decode unit tests: accepts one decoded
// instruction at a time, stalls for a class-dependent latency, then retires it and advances PC.
package exu_resp_bfm_pkg;
  localparam int unsigned ADDR_WIDTH = 12;
  localparam int unsigned MEM_OPS = 6;
  localparam int unsigned OP7_OPS = 22;

  typedef struct packed {
    logic op_and;
    logic op_tad;
    logic op_isz;
    logic op_dca;
    logic op_jms;
    logic op_jmp;
    logic [ADDR_WIDTH-1:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic nop;
    logic iac;
    logic ral;
    logic rtl;
    logic rar;
    logic rtr;
    logic cml;
    logic cma;
    logic cia;
    logic cll;
    logic cla1;
    logic cla_cll;
    logic hlt;
    logic osr;
    logic skp;
    logic snl;
    logic szl;
    logic sza;
    logic sna;
    logic sma;
    logic spa;
    logic cla2;
  } pdp_op7_opcode_s;
endpackage

module exu_resp_bfm
  import exu_resp_bfm_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 12'o0200,
  parameter int unsigned MEM_LAT = 4,
  parameter int unsigned JMP_LAT = 2,
  parameter int unsigned OP7_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  pdp_mem_opcode_s       pdp_mem_opcode,
  input  pdp_op7_opcode_s       pdp_op7_opcode,
  input  logic                  skip_taken,
  output logic                  stall,
  output logic [ADDR_WIDTH-1:0] PC_value,
  output logic [15:0]           instr_count,
  output logic                  protocol_err,
  output logic                  halted
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned FLAG_W = MEM_OPS + OP7_OPS;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_EXEC     = 2'd1;
  localparam logic [1:0] S_WAIT_CLR = 2'd2;
  localparam logic [1:0] S_HALTED   = 2'd3;

  localparam logic [2:0] K_INC1 = 3'd0;
  localparam logic [2:0] K_INC2 = 3'd1;
  localparam logic [2:0] K_COND = 3'd2;
  localparam logic [2:0] K_JMP  = 3'd3;
  localparam logic [2:0] K_JMS  = 3'd4;
  localparam logic [2:0] K_HLT  = 3'd5;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            kind_q, kind_d;
  logic                  skip_q, skip_d;
  pdp_mem_opcode_s       held_mem_q, held_mem_d;
  pdp_op7_opcode_s       held_op7_q, held_op7_d;
  logic [ADDR_WIDTH-1:0] held_base_q, held_base_d;
  logic                  stall_d, halted_d, err_d;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [15:0]           count_d;

  logic [FLAG_W-1:0]     flags;
  logic                  cmd_valid, cmd_changed, multi_hot;
  logic [2:0]            dec_kind;
  logic [CNT_W-1:0]      dec_cnt;
  logic                  accept;

  assign flags = {pdp_mem_opcode.op_and, pdp_mem_opcode.op_tad, pdp_mem_opcode.op_isz,
                  pdp_mem_opcode.op_dca, pdp_mem_opcode.op_jms, pdp_mem_opcode.op_jmp,
                  pdp_op7_opcode};
  assign cmd_valid = |flags;
  assign multi_hot = |(flags & (flags - FLAG_W'(1)));
  assign cmd_changed = (pdp_mem_opcode != held_mem_q) || (pdp_op7_opcode != held_op7_q) ||
                       (base_addr != held_base_q);

  // Instruction class decode; encoding violations fall back to NOP behaviour
  always_comb begin
    dec_kind = K_INC1;
    dec_cnt  = CNT_W'(OP7_LAT - 1);
    if (multi_hot) begin
      dec_kind = K_INC1;
      dec_cnt  = CNT_W'(OP7_LAT - 1);
    end else if (pdp_mem_opcode.op_jmp) begin
      dec_kind = K_JMP;
      dec_cnt  = CNT_W'(JMP_LAT - 1);
    end else if (pdp_mem_opcode.op_jms) begin
      dec_kind = K_JMS;
      dec_cnt  = CNT_W'(MEM_LAT - 1);
    end else if (pdp_mem_opcode.op_and || pdp_mem_opcode.op_tad ||
                 pdp_mem_opcode.op_isz || pdp_mem_opcode.op_dca) begin
      dec_kind = K_INC1;
      dec_cnt  = CNT_W'(MEM_LAT - 1);
    end else if (pdp_op7_opcode.hlt) begin
      dec_kind = K_HLT;
    end else if (pdp_op7_opcode.skp) begin
      dec_kind = K_INC2;
    end else if (pdp_op7_opcode.spa || pdp_op7_opcode.sma || pdp_op7_opcode.sna ||
                 pdp_op7_opcode.sza || pdp_op7_opcode.szl || pdp_op7_opcode.snl) begin
      dec_kind = K_COND;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kind_d      = kind_q;
    skip_d      = skip_q;
    held_mem_d  = held_mem_q;
    held_op7_d  = held_op7_q;
    held_base_d = held_base_q;
    stall_d     = stall;
    halted_d    = halted;
    err_d       = protocol_err;
    pc_d        = PC_value;
    count_d     = instr_count;
    accept      = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall_d = 1'b0;
        accept  = cmd_valid;
      end
      S_EXEC: begin
        if (cmd_changed) err_d = 1'b1;
        if (cnt_q == '0) begin
          count_d = instr_count + 16'd1;
          case (kind_q)
            K_JMP:   pc_d = held_mem_q.mem_inst_addr;
            K_JMS:   pc_d = held_mem_q.mem_inst_addr + ADDR_WIDTH'(1);
            K_INC2:  pc_d = PC_value + ADDR_WIDTH'(2);
            K_COND:  pc_d = PC_value + (skip_q ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));
            K_HLT:   pc_d = PC_value;
            default: pc_d = PC_value + ADDR_WIDTH'(1);
          endcase
          if (kind_q == K_HLT) begin
            state_d  = S_HALTED;
            stall_d  = 1'b1;
            halted_d = 1'b1;
          end else begin
            state_d = S_WAIT_CLR;
            stall_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT_CLR: begin
        stall_d = 1'b0;
        if (!cmd_valid) state_d = S_IDLE;
        else if (cmd_changed) accept = 1'b1;
      end
      S_HALTED: begin
        stall_d  = 1'b1;
        halted_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d     = S_EXEC;
      stall_d     = 1'b1;
      cnt_d       = dec_cnt;
      kind_d      = dec_kind;
      skip_d      = skip_taken;
      held_mem_d  = pdp_mem_opcode;
      held_op7_d  = pdp_op7_opcode;
      held_base_d = base_addr;
      if (multi_hot) err_d = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      kind_q       <= K_INC1;
      skip_q       <= 1'b0;
      held_mem_q   <= '0;
      held_op7_q   <= '0;
      held_base_q  <= '0;
      stall        <= 1'b0;
      halted       <= 1'b0;
      protocol_err <= 1'b0;
      PC_value     <= RESET_PC;
      instr_count  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kind_q       <= kind_d;
      skip_q       <= skip_d;
      held_mem_q   <= held_mem_d;
      held_op7_q   <= held_op7_d;
      held_base_q  <= held_base_d;
      stall        <= stall_d;
      halted       <= halted_d;
      protocol_err <= err_d;
      PC_value     <= pc_d;
      instr_count  <= count_d;
    end
  end

endmodule

// File: tb/tb_exu_resp_bfm.sv
// Directed bench for exu_resp_bfm: latency, PC update rules, error flagging and halt/reset.
module tb_exu_resp_bfm;
  import exu_resp_bfm_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [ADDR_WIDTH-1:0] base_addr;
  pdp_mem_opcode_s       mem;
  pdp_op7_opcode_s       op7;
  logic                  skip_taken;
  logic                  stall;
  logic [ADDR_WIDTH-1:0] pc;
  logic [15:0]           count;
  logic                  err;
  logic                  halted;

  int checks = 0;
  int errors = 0;
  logic [ADDR_WIDTH-1:0] exp_pc;
  logic [15:0]           exp_count;

  always #5 clk = ~clk;

  exu_resp_bfm dut (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr),
    .pdp_mem_opcode(mem), .pdp_op7_opcode(op7), .skip_taken(skip_taken),
    .stall(stall), .PC_value(pc), .instr_count(count),
    .protocol_err(err), .halted(halted)
  );

  task automatic clear_cmd();
    mem = '0;
    op7 = '0;
    skip_taken = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mem = '0;
    op7 = '0;
    skip_taken = 1'b0;
    base_addr = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp_pc = 12'o0200;
    exp_count = 16'd0;
  endtask

  // Inputs already driven at a negedge; counts stall-high cycles after the accept edge.
  // mode 1 swaps the command to JMP 50 mid-EXEC, mode 2 drops skip_taken after accept.
  task automatic run_cmd(output int cyc, input int mode);
    cyc = 0;
    @(posedge clk);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (stall) cyc++;
      else break;
      if (i == 0 && mode == 1) begin
        mem = '0;
        mem.op_jmp = 1'b1;
        mem.mem_inst_addr = 12'd50;
      end
      if (i == 0 && mode == 2) skip_taken = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    repeat (10) @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
    checks++; if (pc !== 12'o0200) begin errors++; $display("FAIL reset_pc: got %0o want 200", pc); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", halted); end
  endtask

  task automatic test_tad();
    int cyc;
    base_addr = 12'o0200;
    mem = '0; mem.op_tad = 1'b1; mem.mem_inst_addr = 12'd3;
    run_cmd(cyc, 0);
    exp_pc = exp_pc + 12'd1; exp_count = exp_count + 16'd1;
    checks++; if (cyc != 4) begin errors++; $display("FAIL tad_stall: got %0d want 4", cyc); end
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL tad_pc: got %0o want %0o", pc, exp_pc); end
    checks++; if (count !== exp_count) begin errors++; $display("FAIL tad_count: got %0d want %0d", count, exp_count); end
    repeat (4) @(negedge clk);
    checks++; if (stall !== 1'b0 || count !== exp_count) begin
      errors++; $display("FAIL tad_no_reexec: stall %0b count %0d want 0 %0d", stall, count, exp_count);
    end
    clear_cmd();
  endtask

  task automatic test_jmp_jms();
    int cyc;
    mem = '0; mem.op_jmp = 1'b1; mem.mem_inst_addr = 12'd11;
    run_cmd(cyc, 0);
    exp_count = exp_count + 16'd1;
    checks++; if (cyc != 2) begin errors++; $display("FAIL jmp_stall: got %0d want 2", cyc); end
    checks++; if (pc !== 12'd11) begin errors++; $display("FAIL jmp_pc: got %0d want 11", pc); end
    clear_cmd();
    mem = '0; mem.op_jms = 1'b1; mem.mem_inst_addr = 12'd9;
    run_cmd(cyc, 0);
    exp_count = exp_count + 16'd1;
    checks++; if (cyc != 4) begin errors++; $display("FAIL jms_stall: got %0d want 4", cyc); end
    checks++; if (pc !== 12'd10) begin errors++; $display("FAIL jms_pc: got %0d want 10", pc); end
    checks++; if (count !== exp_count) begin errors++; $display("FAIL jms_count: got %0d want %0d", count, exp_count); end
  endtask

  // New command replaces the held one without an idle gap
  task automatic test_back_to_back();
    int cyc;
    mem = '0; mem.op_jmp = 1'b1; mem.mem_inst_addr = 12'd20;
    run_cmd(cyc, 0);
    exp_count = exp_count + 16'd1;
    checks++; if (cyc != 2 || pc !== 12'd20) begin
      errors++; $display("FAIL b2b_jmp: stall %0d pc %0d want 2 20", cyc, pc);
    end
    checks++; if (count !== exp_count) begin errors++; $display("FAIL b2b_count: got %0d want %0d", count, exp_count); end
    clear_cmd();
  endtask

  task automatic test_wrap_skip();
    int cyc;
    mem = '0; mem.op_jmp = 1'b1; mem.mem_inst_addr = 12'o7777;
    run_cmd(cyc, 0);
    checks++; if (pc !== 12'o7777) begin errors++; $display("FAIL wrap_jmp: got %0o want 7777", pc); end
    clear_cmd();
    op7 = '0; op7.skp = 1'b1;
    run_cmd(cyc, 0);
    checks++; if (cyc != 1 || pc !== 12'o0001) begin
      errors++; $display("FAIL skp_wrap: stall %0d pc %0o want 1 0001", cyc, pc);
    end
    clear_cmd();
    op7 = '0; op7.sza = 1'b1; skip_taken = 1'b0;
    run_cmd(cyc, 0);
    checks++; if (pc !== 12'o0002) begin errors++; $display("FAIL sza_notaken: got %0o want 2", pc); end
    clear_cmd();
    op7 = '0; op7.snl = 1'b1; skip_taken = 1'b1;
    run_cmd(cyc, 2);
    checks++; if (pc !== 12'o0004) begin errors++; $display("FAIL snl_taken_latched: got %0o want 4", pc); end
    clear_cmd();
    op7 = '0; op7.iac = 1'b1;
    run_cmd(cyc, 0);
    checks++; if (pc !== 12'o0005 || err !== 1'b0) begin
      errors++; $display("FAIL iac_pc: pc %0o err %0b want 5 0", pc, err);
    end
    clear_cmd();
  endtask

  task automatic test_encoding();
    int cyc;
    logic [ADDR_WIDTH-1:0] pc0;
    pc0 = pc;
    mem = '0; mem.op_and = 1'b1; mem.mem_inst_addr = 12'd7;
    op7 = '0; op7.cla1 = 1'b1;
    run_cmd(cyc, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL enc_err: got %0b want 1", err); end
    checks++; if (cyc != 1 || pc !== pc0 + 12'd1) begin
      errors++; $display("FAIL enc_nop: stall %0d pc %0o want 1 %0o", cyc, pc, pc0 + 12'd1);
    end
    clear_cmd();
    op7 = '0; op7.cma = 1'b1;
    run_cmd(cyc, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL enc_sticky: got %0b want 1", err); end
    clear_cmd();
    do_reset();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL enc_reset_clear: got %0b want 0", err); end
    mem = '0; mem.op_tad = 1'b1; mem.mem_inst_addr = 12'd3;
    run_cmd(cyc, 1);
    clear_cmd();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL midexec_err: got %0b want 1", err); end
    checks++; if (cyc != 4 || pc !== 12'o0201) begin
      errors++; $display("FAIL midexec_latched: stall %0d pc %0o want 4 201", cyc, pc);
    end
  endtask

  task automatic test_halt();
    op7 = '0; op7.hlt = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    clear_cmd();
    checks++; if (halted !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL hlt_state: halted %0b stall %0b want 1 1", halted, stall);
    end
    checks++; if (pc !== 12'o0201 || count !== 16'd2) begin
      errors++; $display("FAIL hlt_retire: pc %0o count %0d want 201 2", pc, count);
    end
    mem = '0; mem.op_jmp = 1'b1; mem.mem_inst_addr = 12'd40;
    repeat (6) @(negedge clk);
    checks++; if (pc !== 12'o0201 || count !== 16'd2 || stall !== 1'b1) begin
      errors++; $display("FAIL hlt_frozen: pc %0o count %0d stall %0b want 201 2 1", pc, count, stall);
    end
    do_reset();
    checks++; if (halted !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL hlt_reset: halted %0b stall %0b want 0 0", halted, stall);
    end
  endtask

  task automatic test_reset_mid_exec();
    op7 = '0; op7.iac = 1'b1;
    @(negedge clk);
    clear_cmd();
    mem = '0; mem.op_and = 1'b1; op7.cla1 = 1'b1;
    @(negedge clk);
    clear_cmd();
    mem = '0; mem.op_tad = 1'b1; mem.mem_inst_addr = 12'd3;
    @(posedge clk);
    repeat (2) @(negedge clk);
    checks++; if (stall !== 1'b1 || err !== 1'b1 || count !== 16'd2) begin
      errors++; $display("FAIL pre_reset: stall %0b err %0b count %0d want 1 1 2", stall, err, count);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0 || pc !== 12'o0200 || count !== 16'd0 || err !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL reset_mid_exec: stall %0b pc %0o count %0d err %0b halted %0b", stall, pc, count, err, halted);
    end
    mem = '0;
    op7 = '0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    base_addr = '0;
    mem = '0;
    op7 = '0;
    skip_taken = 1'b0;
    @(negedge clk);
    test_reset();
    test_tad();
    test_jmp_jms();
    test_back_to_back();
    test_wrap_skip();
    test_encoding();
    test_halt();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
